// File: rtl/scan_pkg.sv
// scan_pkg: shared types and constants for the scan select generator.
//   state_t  - scan FSM states
//   NUM_IDX  - number of scanned positions (decoder outputs)
//   IDX_W    - width of the position index
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } state_t;

  localparam int unsigned NUM_IDX = 8;
  localparam int unsigned IDX_W   = 3;

endpackage

// File: rtl/scan_sel_gen_next_idx.sv
// scan_next_idx: combinational search for the next enabled scan position.
// Ports:
//   idx  - current index; search starts strictly above it and wraps mod NUM_IDX
//   mask - per-index enable, bit i enables index i
//   nxt  - nearest enabled index above idx (idx itself if it is the only one)
//   wrap - advance crosses the frame boundary (nxt <= idx)
//   none - no index enabled; nxt/wrap are meaningless
module scan_next_idx
  import scan_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic [NUM_IDX-1:0] mask,
  output logic [IDX_W-1:0]   nxt,
  output logic               wrap,
  output logic               none
);

  logic [IDX_W-1:0] pos;

  // Walk distances from farthest to nearest so the nearest hit is the last
  // assignment; distance NUM_IDX truncates to idx itself (self re-select).
  always_comb begin
    nxt = idx;
    pos = idx;
    for (int unsigned k = NUM_IDX; k >= 1; k--) begin
      pos = idx + IDX_W'(k);
      if (mask[pos]) begin
        nxt = pos;
      end
    end
  end

  assign wrap = (nxt <= idx);
  assign none = (mask == '0);

endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: select generator feeding a 3-to-8 one-hot decoder.
// Steps a 3-bit index {A,B,C} through 8 positions, holding each for
// DWELL_CYCLES with disp_on high, then BLANK_CYCLES with disp_on low before
// the index changes. frame_done pulses on the first ACTIVE cycle of a frame.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - scan enable (level); low returns to IDLE on the next edge
//   mask       - per-index enable (only when SCAN_SKIP_EN is defined)
//   A, B, C    - registered index bits 2, 1, 0
//   disp_on    - registered display enable
//   frame_done - registered one-cycle frame pulse
// Build option: define SCAN_SKIP_EN to add the mask port and skip disabled
// indices.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
`ifdef SCAN_SKIP_EN
  input  logic [NUM_IDX-1:0] mask,
`endif
  output logic               A,
  output logic               B,
  output logic               C,
  output logic               disp_on,
  output logic               frame_done
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             disp_q, disp_d;
  logic             fd_q, fd_d;
  // park: waiting in BLANK for a non-empty mask; park_first: the wait began
  // at IDLE exit, so the eventual exit is a scan start (first index, no pulse).
  logic             park_q, park_d;
  logic             park_first_q, park_first_d;

  logic [IDX_W-1:0] adv_idx;
  logic [IDX_W-1:0] first_idx;
  logic             adv_wrap;
  logic             adv_none;
  logic             go_start;
  logic             go_adv;

`ifdef SCAN_SKIP_EN
  logic [IDX_W-1:0] query_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             nxt_none;

  // Searching above the top index yields the lowest set bit, i.e. the first
  // index of a frame, so one search unit serves both start and advance.
  assign query_idx = ((state_q == IDLE) || park_first_q) ? '1 : idx_q;

  scan_next_idx u_next (
    .idx  (query_idx),
    .mask (mask),
    .nxt  (nxt_idx),
    .wrap (nxt_wrap),
    .none (nxt_none)
  );

  assign adv_idx   = nxt_idx;
  assign first_idx = nxt_idx;
  assign adv_wrap  = nxt_wrap;
  assign adv_none  = nxt_none;
`else
  assign adv_idx   = idx_q + 1'b1;
  assign first_idx = '0;
  assign adv_wrap  = (idx_q == '1);
  assign adv_none  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    disp_d       = disp_q;
    fd_d         = 1'b0;
    park_d       = park_q;
    park_first_d = park_first_q;
    go_start     = 1'b0;
    go_adv       = 1'b0;

    if (!en) begin
      state_d      = IDLE;
      idx_d        = '0;
      cnt_d        = '0;
      disp_d       = 1'b0;
      park_d       = 1'b0;
      park_first_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          go_start = 1'b1;
        end
        ACTIVE: begin
          disp_d = 1'b1;
          if (cnt_q == DWELL_LAST) begin
            if (BLANK_CYCLES == 0) begin
              go_adv = 1'b1;
            end else begin
              state_d = BLANK;
              cnt_d   = '0;
              disp_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          disp_d = 1'b0;
          if (park_q) begin
            go_start = park_first_q;
            go_adv   = !park_first_q;
          end else if (cnt_q == BLANK_LAST) begin
            go_adv = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (go_start || go_adv) begin
        if (adv_none) begin
          state_d      = BLANK;
          cnt_d        = '0;
          disp_d       = 1'b0;
          park_d       = 1'b1;
          park_first_d = go_start;
        end else begin
          state_d      = ACTIVE;
          cnt_d        = '0;
          disp_d       = 1'b1;
          park_d       = 1'b0;
          park_first_d = 1'b0;
          idx_d        = go_start ? first_idx : adv_idx;
          fd_d         = go_adv && adv_wrap;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= 1'b0;
      fd_q         <= 1'b0;
      park_q       <= 1'b0;
      park_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      fd_q         <= fd_d;
      park_q       <= park_d;
      park_first_q <= park_first_d;
    end
  end

  assign A          = idx_q[2];
  assign B          = idx_q[1];
  assign C          = idx_q[0];
  assign disp_on    = disp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// tb_scan_sel_gen: directed self-checking bench for scan_sel_gen.
// u_dut runs DWELL=4/BLANK=2, u_dut_nb runs DWELL=4/BLANK=0.
// Mask-related scenarios are built only when SCAN_SKIP_EN is defined.
module tb_scan_sel_gen;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic en_nb;
`ifdef SCAN_SKIP_EN
  logic [7:0] mask;
`endif

  logic a, b, c, disp_on, frame_done;
  logic a_nb, b_nb, c_nb, disp_on_nb, frame_done_nb;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  scan_sel_gen #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2),
    .CNT_W        (16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef SCAN_SKIP_EN
    .mask       (mask),
`endif
    .A          (a),
    .B          (b),
    .C          (c),
    .disp_on    (disp_on),
    .frame_done (frame_done)
  );

  scan_sel_gen #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (0),
    .CNT_W        (16)
  ) u_dut_nb (
    .clk        (clk),
    .rst        (rst),
    .en         (en_nb),
`ifdef SCAN_SKIP_EN
    .mask       (mask),
`endif
    .A          (a_nb),
    .B          (b_nb),
    .C          (c_nb),
    .disp_on    (disp_on_nb),
    .frame_done (frame_done_nb)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned idx_of(input logic x2, input logic x1, input logic x0);
    return int'({x2, x1, x0});
  endfunction

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned found;
    rst   = 1'b1;
    en    = 1'b0;
    en_nb = 1'b0;
`ifdef SCAN_SKIP_EN
    mask  = 8'hFF;
`endif
    #12;
    check("rst_idx",  idx_of(a, b, c), 0);
    check("rst_disp", 32'(disp_on), 0);
    check("rst_fd",   32'(frame_done), 0);
    check("rst_nb",   32'({a_nb, b_nb, c_nb, disp_on_nb, frame_done_nb}), 0);

    // Normal scan: edge e counted from the first edge with en=1.
    tick;
    rst = 1'b0;
    en  = 1'b1;
    for (int unsigned e = 1; e <= 49; e++) begin
      int unsigned q, p;
      tick;
      q = (e - 1) / 6;
      p = (e - 1) % 6;
      check("norm_idx",  idx_of(a, b, c), q % 8);
      check("norm_disp", 32'(disp_on), (p < 4) ? 1 : 0);
      check("norm_fd",   32'(frame_done), (e > 1 && p == 0 && (q % 8) == 0) ? 1 : 0);
    end

    // Asynchronous reset while idx=5 is displayed.
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (idx_of(a, b, c) == 5 && disp_on) found = 1;
      else tick;
    end
    check("find_idx5", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_idx",  idx_of(a, b, c), 0);
    check("arst_disp", 32'(disp_on), 0);
    tick;
    rst = 1'b0;
    tick;
    check("restart_idx",  idx_of(a, b, c), 0);
    check("restart_disp", 32'(disp_on), 1);
    check("restart_fd",   32'(frame_done), 0);

    // Disable during idx=3 blanking.
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (idx_of(a, b, c) == 3 && !disp_on) found = 1;
      else tick;
    end
    check("find_idx3_blank", found, 1);
    en = 1'b0;
    tick;
    check("dis_idx",  idx_of(a, b, c), 0);
    check("dis_disp", 32'(disp_on), 0);
    check("dis_fd",   32'(frame_done), 0);
    tick;
    check("idle_disp", 32'(disp_on), 0);
    en = 1'b1;
    tick;
    check("reen_idx",  idx_of(a, b, c), 0);
    check("reen_disp", 32'(disp_on), 1);
    check("reen_fd",   32'(frame_done), 0);
    for (int unsigned e = 2; e <= 6; e++) begin
      tick;
      check("reen_idx_hold", idx_of(a, b, c), 0);
      check("reen_fd_quiet", 32'(frame_done), 0);
    end

    // No blanking instance.
    en  = 1'b0;
    rst = 1'b1;
    #1;
    rst   = 1'b0;
    en_nb = 1'b1;
    for (int unsigned e = 1; e <= 40; e++) begin
      tick;
      check("nb_idx",  idx_of(a_nb, b_nb, c_nb), ((e - 1) / 4) % 8);
      check("nb_disp", 32'(disp_on_nb), 1);
      check("nb_fd",   32'(frame_done_nb), (e > 1 && ((e - 1) % 32) == 0) ? 1 : 0);
    end
    en_nb = 1'b0;

`ifdef SCAN_SKIP_EN
    // Sparse mask: 2,5,7,2,...
    rst = 1'b1;
    #1;
    rst  = 1'b0;
    mask = 8'b1010_0100;
    en   = 1'b1;
    for (int unsigned e = 1; e <= 40; e++) begin
      int unsigned q, p, exp_idx;
      tick;
      q = (e - 1) / 6;
      p = (e - 1) % 6;
      case (q % 3)
        0:       exp_idx = 2;
        1:       exp_idx = 5;
        default: exp_idx = 7;
      endcase
      check("skip_idx",  idx_of(a, b, c), exp_idx);
      check("skip_disp", 32'(disp_on), (p < 4) ? 1 : 0);
      check("skip_fd",   32'(frame_done), (e > 1 && ((e - 1) % 18) == 0) ? 1 : 0);
    end

    // Empty mask parks in blanking, then a single bit re-selects itself.
    en  = 1'b0;
    rst = 1'b1;
    #1;
    rst  = 1'b0;
    mask = 8'h00;
    en   = 1'b1;
    for (int unsigned e = 1; e <= 6; e++) begin
      tick;
      check("park_idx",  idx_of(a, b, c), 0);
      check("park_disp", 32'(disp_on), 0);
      check("park_fd",   32'(frame_done), 0);
    end
    mask = 8'h01;
    tick;
    check("unpark_idx",  idx_of(a, b, c), 0);
    check("unpark_disp", 32'(disp_on), 1);
    for (int unsigned f = 2; f <= 20; f++) begin
      tick;
      check("single_idx",  idx_of(a, b, c), 0);
      check("single_disp", 32'(disp_on), (((f - 1) % 6) < 4) ? 1 : 0);
      check("single_fd",   32'(frame_done), (((f - 1) % 6) == 0) ? 1 : 0);
    end
    en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
Name: scan_sel_gen

Overview:
- Sequential select generator that sits directly upstream of the 3-to-8 one-hot decoder.
- Cycles a 3-bit digit/row index, driven out as A (MSB), B, C, across 8 positions with a programmable dwell time per position.
- Inserts a blanking gap before each index change, so the decoded one-hot lines only switch while the display/driver is disabled.
- Emits a frame-complete pulse once per full scan.

Parameters:
- DWELL_CYCLES, 50000, clock cycles disp_on stays high per index; must be >=1 and <2**CNT_W.
- BLANK_CYCLES, 4, clock cycles of blanking between indices; 0 removes the BLANK state; must be <2**CNT_W.
- CNT_W, 16, width of the shared dwell/blank counter.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, scan enable, level-sensitive, sampled each clock.
- mask, input, 8, per-index enable; bit i enables index i. Port present only with SCAN_SKIP_EN.
- A, output, 1, index bit 2, registered.
- B, output, 1, index bit 1, registered.
- C, output, 1, index bit 0, registered.
- disp_on, output, 1, high while the current index is being displayed, registered.
- frame_done, output, 1, one-cycle pulse at the start of each new frame, registered.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, idx=0, cnt=0, A/B/C=0, disp_on=0, frame_done=0.
- All outputs are flops. {A,B,C} always equals idx.
- State IDLE:
  - Outputs idx=0, disp_on=0.
  - On an edge with en=1: go to ACTIVE, cnt=0, idx=first index (0, or lowest set mask bit with the feature), disp_on=1.
  - frame_done is NOT pulsed on this start.
- State ACTIVE:
  - disp_on=1; cnt increments each cycle.
  - At cnt==DWELL_CYCLES-1: go to BLANK, cnt=0, disp_on=0.
  - If BLANK_CYCLES==0, go straight to ACTIVE with the next index instead.
  - disp_on is therefore high for exactly DWELL_CYCLES cycles per index.
- State BLANK:
  - disp_on=0, idx held.
  - At cnt==BLANK_CYCLES-1: idx advances to the next index, state=ACTIVE, cnt=0, disp_on=1.
- Index advance: idx=(idx+1) mod 8; wrap 7->0 is the frame boundary.
- frame_done: high for exactly one cycle, in the first ACTIVE cycle of a new frame (same edge idx wraps).
- Index change timing:
  - With BLANK_CYCLES>0, idx changes only on the edge where disp_on rises; it never changes while disp_on is high.
  - With BLANK_CYCLES=0, idx changes and disp_on stays 1.
- en=0 in any state: next edge goes to IDLE, idx=0, cnt=0, disp_on=0, frame_done=0. A partial frame is abandoned.
- en=0 and a dwell/blank terminal count on the same edge: en wins.
- Scan period per index: DWELL_CYCLES+BLANK_CYCLES. Frame period: 8*(DWELL_CYCLES+BLANK_CYCLES).
- Counter compares are CNT_W-bit unsigned.

Optional Feature:
- Macro SCAN_SKIP_EN.
- Defined:
  - mask port exists; the next index is the nearest set mask bit strictly above idx, wrapping modulo 8.
  - The frame boundary (frame_done) is any advance where the new idx <= the old idx; this includes a single set bit re-selecting itself.
  - mask is sampled at the advance edge and at the IDLE exit.
  - If mask==0 at an advance or IDLE exit: enter or stay in BLANK with disp_on=0, idx held, cnt held at 0. The first edge with mask!=0 advances as normal.
- Undefined: no mask port; all 8 indices are scanned in order.

Decomposition:
- Shared package scan_pkg:
  - state typedef enum {IDLE, ACTIVE, BLANK}
  - localparams NUM_IDX=8, IDX_W=3
- One combinational sub-module, scan_next_idx (inputs: idx, mask; outputs: next idx, wrap, none-set). Instantiated only under SCAN_SKIP_EN; otherwise next index is an inline increment.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2 unless stated):
- Normal scan: rst pulse, then en=1 held.
  - {A,B,C} steps 0..7 then 0.
  - disp_on pattern per index: 4 high, 2 low.
  - First frame_done on edge 48 after start; none at start.
- Reset mid-operation: assert rst asynchronously (between edges) while idx=5, ACTIVE.
  - A/B/C/disp_on drop to 0 immediately, without waiting for a clock.
  - After release with en=1, restart at idx 0.
- Disable mid-frame: en->0 during idx=3 BLANK.
  - Next edge: IDLE, idx=0, disp_on=0.
  - Re-enable: idx=0 with no frame_done pulse.
- No blanking (BLANK_CYCLES=0): disp_on stays constant 1, idx changes every 4 cycles, frame_done every 32 cycles.
- SCAN_SKIP_EN, mask=8'b1010_0100: idx sequence 2,5,7,2,...; frame_done on each 7->2 advance.
- SCAN_SKIP_EN, mask=0 then mask=8'h01:
  - With mask=0: disp_on held 0, idx held.
  - After mask=8'h01: idx stays 0, frame_done pulses every 6 cycles.
